// File: rtl/dma_fifo_pkg.sv
// Shared constants, helpers and the elaboration-time parameter check for the DMA FIFO family.
package dma_fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 50;
    localparam int unsigned DEFAULT_DEPTH      = 4;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

`ifndef DMA_FIFO_PARAM_CHECK
// Generate-scope guard: stops elaboration with a message when cond is false.
`define DMA_FIFO_PARAM_CHECK(label, cond, msg) \
    if (!(cond)) begin : label \
        $error(msg); \
    end
`endif

// File: rtl/dma_param_fifo_ram.sv
// Simple dual-port storage: one write port, one read port with registered, enabled output.
module dma_param_fifo_ram
    import dma_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      rd_en,
    input  logic [clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array write and registered read; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dma_param_fifo.sv
// First-word-fall-through FIFO over a registered-read RAM, with occupancy flags and error pulses.
module dma_param_fifo
    import dma_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned AFULL_LEVEL  = DEPTH - 1,
    parameter int unsigned AEMPTY_LEVEL = 1
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic                    FLUSH,
    input  logic                    WR_EN,
    input  logic [DATA_WIDTH-1:0]   WR_DATA,
    input  logic                    RD_EN,
    output logic [DATA_WIDTH-1:0]   RD_DATA,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic                    ALMOST_FULL,
    output logic                    ALMOST_EMPTY,
    output logic [clog2(DEPTH):0]   COUNT,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);

    `DMA_FIFO_PARAM_CHECK(g_chk_width, (DATA_WIDTH >= 1) && (DATA_WIDTH <= 128), "dma_param_fifo: DATA_WIDTH must be 1..128")
    `DMA_FIFO_PARAM_CHECK(g_chk_depth, (DEPTH >= 2) && (DEPTH <= 64) && ((DEPTH & (DEPTH - 1)) == 0), "dma_param_fifo: DEPTH must be a power of two in 2..64")
    `DMA_FIFO_PARAM_CHECK(g_chk_afull, AFULL_LEVEL <= DEPTH, "dma_param_fifo: AFULL_LEVEL must not exceed DEPTH")
    `DMA_FIFO_PARAM_CHECK(g_chk_aempty, AEMPTY_LEVEL < DEPTH, "dma_param_fifo: AEMPTY_LEVEL must be below DEPTH")

    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic                  mid_valid;    // RAM output register holds a fetched, unread word
    logic [DATA_WIDTH-1:0] ram_q;

    logic                  out_valid;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  out_load;
    logic                  mid_free;
    logic                  ram_re;
    logic                  ram_we;
    logic [CW-1:0]         avail;        // words still sitting in the array, not yet fetched
    logic [CW-1:0]         count_nxt;

    // Accept decisions and prefetch control: refill the output stage from the RAM stage,
    // and fetch the next array word whenever the RAM stage is (or is becoming) free.
    always_comb begin
        out_valid = !EMPTY;
        wr_acc    = WR_EN && !FULL;
        rd_acc    = RD_EN && out_valid;
        out_load  = mid_valid && (!out_valid || rd_acc);
        mid_free  = !mid_valid || out_load;
        avail     = COUNT - CW'(out_valid) - CW'(mid_valid);
        ram_re    = !FLUSH && mid_free && (avail != '0);
        ram_we    = !FLUSH && wr_acc;
        count_nxt = COUNT + CW'(wr_acc) - CW'(rd_acc);
    end

    dma_param_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (CLK),
        .wr_en   (ram_we),
        .wr_addr (wptr),
        .wr_data (WR_DATA),
        .rd_en   (ram_re),
        .rd_addr (rptr),
        .rd_data (ram_q)
    );

    // Pointers, occupancy, flags, output holding register; reset and flush both clear everything.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wptr         <= '0;
            rptr         <= '0;
            mid_valid    <= 1'b0;
            COUNT        <= '0;
            RD_DATA      <= '0;
            EMPTY        <= 1'b1;
            ALMOST_EMPTY <= 1'b1;
            FULL         <= 1'b0;
            ALMOST_FULL  <= 1'b0;
            OVERFLOW     <= 1'b0;
            UNDERFLOW    <= 1'b0;
        end else if (FLUSH) begin
            wptr         <= '0;
            rptr         <= '0;
            mid_valid    <= 1'b0;
            COUNT        <= '0;
            RD_DATA      <= '0;
            EMPTY        <= 1'b1;
            ALMOST_EMPTY <= 1'b1;
            FULL         <= 1'b0;
            ALMOST_FULL  <= 1'b0;
            OVERFLOW     <= 1'b0;
            UNDERFLOW    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + AW'(1);
            end
            if (ram_re) begin
                rptr <= rptr + AW'(1);
            end
            mid_valid <= ram_re || (mid_valid && !out_load);
            if (out_load) begin
                RD_DATA <= ram_q;
                EMPTY   <= 1'b0;
            end else if (rd_acc) begin
                EMPTY   <= 1'b1;
            end
            COUNT        <= count_nxt;
            FULL         <= (count_nxt == DEPTH_C);
            ALMOST_FULL  <= (count_nxt >= AFULL_C);
            ALMOST_EMPTY <= (count_nxt <= AEMPTY_C);
            OVERFLOW     <= WR_EN && FULL;
            UNDERFLOW    <= RD_EN && EMPTY;
        end
    end

endmodule

// File: tb/tb_dma_param_fifo.sv
// Directed bench for dma_param_fifo at default parameters (DATA_WIDTH=50, DEPTH=4).
module tb_dma_param_fifo;

    localparam int unsigned DW = 50;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    dma_param_fifo dut (
        .CLK          (clk),
        .RESETN       (rst_n),
        .FLUSH        (flush),
        .WR_EN        (wr_en),
        .WR_DATA      (wr_data),
        .RD_EN        (rd_en),
        .RD_DATA      (rd_data),
        .FULL         (full),
        .EMPTY        (empty),
        .ALMOST_FULL  (almost_full),
        .ALMOST_EMPTY (almost_empty),
        .COUNT        (count),
        .OVERFLOW     (overflow),
        .UNDERFLOW    (underflow)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int wi;
        int ri;
        int cyc;

        // Reset values while RESETN is low
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        step(); step();
        chk("rst_count",   64'(count),        64'd0);
        chk("rst_empty",   64'(empty),        64'd1);
        chk("rst_aempty",  64'(almost_empty), 64'd1);
        chk("rst_full",    64'(full),         64'd0);
        chk("rst_afull",   64'(almost_full),  64'd0);
        chk("rst_ovf",     64'(overflow),     64'd0);
        chk("rst_unf",     64'(underflow),    64'd0);
        chk("rst_data",    64'(rd_data),      64'd0);
        rst_n = 1'b1;

        // Latency: write on the first edge after release, visible two edges later
        wr_en = 1'b1; wr_data = DW'(64'h2A);
        step();
        wr_en = 1'b0;
        chk("lat_count_k",  64'(count), 64'd1);
        chk("lat_empty_k",  64'(empty), 64'd1);
        step();
        chk("lat_empty_k1", 64'(empty), 64'd1);
        step();
        chk("lat_empty_k2", 64'(empty),   64'd0);
        chk("lat_data_k2",  64'(rd_data), 64'h2A);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("lat_pop_count", 64'(count),     64'd0);
        chk("lat_pop_empty", 64'(empty),     64'd1);
        chk("lat_pop_unf",   64'(underflow), 64'd0);

        // Underflow: single pulse
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("unf_pulse", 64'(underflow), 64'd1);
        step();
        chk("unf_clear", 64'(underflow), 64'd0);

        // Fill 1..4 without reads
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1; wr_data = DW'(i);
            step();
            chk("fill_count", 64'(count),       64'(i));
            chk("fill_afull", 64'(almost_full), 64'(i >= 3));
            chk("fill_full",  64'(full),        64'(i == 4));
        end
        wr_en = 1'b0;
        chk("fill_data",  64'(rd_data), 64'h1);
        chk("fill_empty", 64'(empty),   64'd0);

        // Overflow: write 5 while full with a read; 1 pops, 5 is dropped
        wr_en = 1'b1; wr_data = DW'(64'h5); rd_en = 1'b1;
        step();
        wr_en = 1'b0;
        chk("ovf_count", 64'(count),    64'd3);
        chk("ovf_pulse", 64'(overflow), 64'd1);
        chk("ovf_data",  64'(rd_data),  64'h2);
        chk("ovf_full",  64'(full),     64'd0);
        step();
        chk("ovf_clear", 64'(overflow), 64'd0);
        chk("drain_3",   64'(rd_data),  64'h3);
        step();
        chk("drain_4",   64'(rd_data),  64'h4);
        step();
        rd_en = 1'b0;
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_count", 64'(count), 64'd0);

        // Streaming 0..19 with simultaneous read/write; must finish with no bubble
        wi = 0; ri = 0; cyc = 0;
        while (ri < 20 && cyc < 40) begin
            wr_en   = (wi < 20);
            wr_data = DW'(wi);
            rd_en   = !empty;
            if (rd_en) begin
                chk("stream_data", 64'(rd_data), 64'(ri));
                ri++;
            end
            step();
            cyc++;
            if (wr_en) wi++;
            if (cyc == 10) chk("stream_count", 64'(count), 64'd3);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        chk("stream_done",   64'(ri),    64'd20);
        chk("stream_cycles", 64'(cyc),   64'd23);
        chk("stream_empty",  64'(empty), 64'd1);
        chk("stream_cnt0",   64'(count), 64'd0);

        // Flush with a concurrent write
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = DW'(64'h10 + 64'(i));
            step();
        end
        wr_en = 1'b0;
        chk("pre_flush_count", 64'(count),   64'd3);
        chk("pre_flush_data",  64'(rd_data), 64'h10);
        flush = 1'b1; wr_en = 1'b1; wr_data = DW'(64'h99);
        step();
        flush = 1'b0; wr_en = 1'b0;
        chk("flush_count",  64'(count),        64'd0);
        chk("flush_empty",  64'(empty),        64'd1);
        chk("flush_full",   64'(full),         64'd0);
        chk("flush_data",   64'(rd_data),      64'd0);
        chk("flush_ovf",    64'(overflow),     64'd0);
        chk("flush_unf",    64'(underflow),    64'd0);
        chk("flush_aempty", 64'(almost_empty), 64'd1);
        wr_en = 1'b1; wr_data = DW'(64'h33);
        step();
        wr_en = 1'b0;
        chk("post_flush_count", 64'(count), 64'd1);
        step(); step();
        chk("post_flush_empty", 64'(empty),   64'd0);
        chk("post_flush_data",  64'(rd_data), 64'h33);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("post_flush_drain", 64'(empty), 64'd1);

        // Asynchronous reset mid-stream with two words held
        wr_en = 1'b1; wr_data = DW'(64'h41);
        step();
        wr_data = DW'(64'h42);
        step();
        wr_en = 1'b0;
        step();
        chk("pre_rst_count", 64'(count),   64'd2);
        chk("pre_rst_data",  64'(rd_data), 64'h41);
        rst_n = 1'b0;
        #2;
        chk("arst_count",  64'(count),        64'd0);
        chk("arst_empty",  64'(empty),        64'd1);
        chk("arst_aempty", 64'(almost_empty), 64'd1);
        chk("arst_full",   64'(full),         64'd0);
        chk("arst_afull",  64'(almost_full),  64'd0);
        chk("arst_ovf",    64'(overflow),     64'd0);
        chk("arst_unf",    64'(underflow),    64'd0);
        chk("arst_data",   64'(rd_data),      64'd0);
        step();
        rst_n = 1'b1;
        wr_en = 1'b1; wr_data = DW'(64'h7);
        step();
        wr_en = 1'b0;
        chk("post_rst_count", 64'(count), 64'd1);
        step(); step();
        chk("post_rst_empty", 64'(empty),   64'd0);
        chk("post_rst_data",  64'(rd_data), 64'h7);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        step(); step();
        chk("post_rst_drain", 64'(empty), 64'd1);
        chk("post_rst_cnt0",  64'(count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_param_fifo.md
DMA_PARAM_FIFO -- requirements
Module: dma_param_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 50: word width, 1..128.
REQ-002 SHALL have parameter DEPTH, default 4: capacity in words, power of two, 2..64.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-1: ALMOST_FULL asserts when COUNT >= AFULL_LEVEL.
REQ-004 SHALL have parameter AEMPTY_LEVEL, default 1: ALMOST_EMPTY asserts when COUNT <= AEMPTY_LEVEL.
REQ-005 SHALL have port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port RESETN, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port FLUSH, input, 1: synchronous clear of contents.
REQ-008 SHALL have port WR_EN, input, 1: write request.
REQ-009 SHALL have port WR_DATA, input, DATA_WIDTH: write word.
REQ-010 SHALL have port RD_EN, input, 1: read acknowledge; pops the word on RD_DATA.
REQ-011 SHALL have port RD_DATA, output, DATA_WIDTH: head word (first-word-fall-through), valid while EMPTY=0.
REQ-012 SHALL have ports FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY, each output, 1, all registered.
REQ-013 SHALL have port COUNT, output, clog2(DEPTH)+1: number of accepted, unread words.
REQ-014 SHALL have ports OVERFLOW and UNDERFLOW, each output, 1: one-cycle error pulses.

Function
REQ-015 SHALL accept a write when WR_EN=1 and FULL=0; data is stored at the write pointer, and the pointer advances modulo DEPTH.
REQ-016 SHALL ignore WR_EN=1 while FULL=1, even if RD_EN=1 in the same cycle; no state change; OVERFLOW=1 in the next cycle only.
REQ-017 SHALL accept a read when RD_EN=1 and EMPTY=0; RD_DATA presents the next word, or EMPTY asserts.
REQ-018 SHALL ignore RD_EN=1 while EMPTY=1; UNDERFLOW=1 in the next cycle only.
REQ-019 SHALL set COUNT on an accepted write +1, on an accepted read -1, and on both in the same cycle unchanged; COUNT never exceeds DEPTH or goes below 0.
REQ-020 SHALL set FULL = (COUNT==DEPTH), ALMOST_FULL and ALMOST_EMPTY from the same COUNT value, all updating on the same edge as COUNT.
REQ-021 SHALL have a storage read latency of one cycle (registered read), plus an output holding register providing first-word-fall-through.
REQ-022 SHALL, for a write accepted on edge k into an empty FIFO, present the word on RD_DATA with EMPTY=0 after edge k+2; COUNT=1 after edge k.
REQ-023 SHALL sustain one read and one write per cycle, with no bubble, once the output register and storage hold data.
REQ-024 SHALL keep RD_DATA stable while EMPTY=0 and RD_EN=0.
REQ-025 SHALL make pointer wrap from DEPTH-1 to 0 transparent; ordering is strictly FIFO.
REQ-026 SHALL treat FLUSH=1 with priority over WR_EN and RD_EN in the same cycle: pointers=0, COUNT=0, EMPTY=1, FULL=0, RD_DATA=0, in-flight read discarded, no OVERFLOW or UNDERFLOW pulse.
REQ-027 SHALL, on the cycle after FLUSH, accept writes normally.
REQ-028 SHALL make behaviour with AFULL_LEVEL > DEPTH or AEMPTY_LEVEL >= DEPTH a parameter error, flagged at elaboration.

Reset
REQ-029 SHALL, with RESETN=0, asynchronously force COUNT=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0, RD_DATA=0, and pointers=0.
REQ-030 SHALL release reset synchronously to CLK; the first write is accepted on the first rising edge with RESETN=1.
REQ-031 SHALL not clear storage array contents on reset; data stored before a reset is unreachable after it.
REQ-032 SHALL treat reset asserted mid-transfer like FLUSH: nothing is returned afterwards.

Structure
REQ-033 SHALL place the clog2 helper, default DATA_WIDTH/DEPTH constants and the parameter-check macro in shared package dma_fifo_pkg.
REQ-034 SHALL instantiate one sub-module, dma_param_fifo_ram: simple dual-port, DEPTH x DATA_WIDTH, write port plus read port with registered output and read enable, no reset on the array.
REQ-035 SHALL keep pointers, COUNT, flags, prefetch control and output register in dma_param_fifo.

Verification
REQ-036 SHALL verify fill: DEPTH=4, write 0x1,0x2,0x3,0x4 on consecutive cycles, no reads -> COUNT=4, FULL=1, ALMOST_FULL=1 from COUNT=3, RD_DATA=0x1.
REQ-037 SHALL verify overflow: when full, write 0x5 with RD_EN=1 -> 0x1 popped, 0x5 dropped, OVERFLOW pulses once, COUNT=3.
REQ-038 SHALL verify streaming: 20 words 0..19 with WR_EN=RD_EN=1 every cycle after first-word latency -> output 0..19 in order, wrap exercised, COUNT steady.
REQ-039 SHALL verify latency: write 0x2A into an empty FIFO at edge k -> COUNT=1 after k, EMPTY=0 and RD_DATA=0x2A after k+2.
REQ-040 SHALL verify underflow and flush: RD_EN while empty -> UNDERFLOW one cycle; 3 words loaded, FLUSH with WR_EN=1 -> COUNT=0, EMPTY=1, no pulses.
REQ-041 SHALL verify reset: RESETN low mid-stream with COUNT=2 -> all outputs at reset values immediately; the next write 0x7 reads back as 0x7.
